// File: rtl/serial_display_rx_pkg.sv
// Shared types and constants for the serial display link receiver.
// Frame layout, flag bit indices, FSM state type and checksum helper.
package serial_display_rx_pkg;

  localparam int          FRAME_BITS = 40;
  localparam logic [7:0]  HEADER     = 8'hA5;
  localparam int          TIMEOUT    = 2047;

  localparam int FLAG_NEG = 0;
  localparam int FLAG_ERR = 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  // XOR of the four leading bytes (header, digits hi/lo, flags).
  function automatic logic [7:0] frame_csum(input logic [31:0] body);
    return body[31:24] ^ body[23:16] ^ body[15:8] ^ body[7:0];
  endfunction

endpackage

// File: rtl/serial_display_rx_sync_edge.sv
// 2-FF synchronizer with rising-edge pulse on the synchronized copy.
// Ports: clk, rst (sync, active-high), d (async in), q (synced), rise (1-cycle pulse).
module serial_display_rx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~prev;

endmodule

// File: rtl/serial_display_rx.sv
// Receiver for the 3-wire serial display link: deserializes 40-bit frames,
// checks header (and checksum with SERIAL_DISPLAY_RX_CHECKSUM_EN defined).
// Ports: clk, rst (sync, active-high), ser_clk/data/data_en (async link),
//   digits[15:0] BCD, flags[7:0], frame_valid/frame_err strobes, busy.
import serial_display_rx_pkg::*;

module serial_display_rx #(
  parameter int         FRAME_BITS = serial_display_rx_pkg::FRAME_BITS,
  parameter logic [7:0] HEADER     = serial_display_rx_pkg::HEADER,
  parameter int         TIMEOUT    = serial_display_rx_pkg::TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_clk,
  input  logic        data,
  input  logic        data_en,
  output logic [15:0] digits,
  output logic [7:0]  flags,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic sck_q;
  logic rise;
  logic dat_q;
  logic den_q;
  logic unused_sck_q;
  logic unused_dat_rise;
  logic unused_den_rise;

  serial_display_rx_sync_edge u_sck (
    .clk  (clk),
    .rst  (rst),
    .d    (ser_clk),
    .q    (sck_q),
    .rise (rise)
  );

  serial_display_rx_sync_edge u_dat (
    .clk  (clk),
    .rst  (rst),
    .d    (data),
    .q    (dat_q),
    .rise (unused_dat_rise)
  );

  serial_display_rx_sync_edge u_den (
    .clk  (clk),
    .rst  (rst),
    .d    (data_en),
    .q    (den_q),
    .rise (unused_den_rise)
  );

  assign unused_sck_q = sck_q;

  state_t                  state;
  state_t                  state_n;
  logic [FRAME_BITS-1:0]   sr;
  logic [CW-1:0]           cnt;
  logic [TW-1:0]           tcnt;
  // Set when a frame ends with data_en still high; blocks restart
  // until data_en has been seen low.
  logic                    wait_low;

  logic start;
  logic shift;
  logic fail;
  logic accept;
  logic reject;
  logic frame_ok;

`ifdef SERIAL_DISPLAY_RX_CHECKSUM_EN
  assign frame_ok = (sr[39:32] == HEADER) &&
                    (sr[7:0] == frame_csum(sr[39:8]));
`else
  logic [7:0] unused_csum;
  assign unused_csum = sr[7:0];
  assign frame_ok    = (sr[39:32] == HEADER);
`endif

  always_comb begin
    state_n = state;
    start   = 1'b0;
    shift   = 1'b0;
    fail    = 1'b0;
    accept  = 1'b0;
    reject  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise && den_q && !wait_low) begin
          start   = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (!den_q) begin
          fail    = 1'b1;
          state_n = IDLE;
        end else if (rise) begin
          shift = 1'b1;
          if (cnt == CW'(FRAME_BITS - 1)) state_n = CHECK;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          fail    = 1'b1;
          state_n = IDLE;
        end
      end
      CHECK: begin
        state_n = IDLE;
        if (frame_ok) accept = 1'b1;
        else          reject = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      wait_low    <= 1'b0;
      digits      <= '0;
      flags       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      frame_valid <= accept;
      frame_err   <= fail | reject;
      busy        <= (state_n != IDLE);

      if (start) begin
        sr   <= {{(FRAME_BITS-1){1'b0}}, dat_q};
        cnt  <= CW'(1);
        tcnt <= TW'(1);
      end else if (shift) begin
        sr   <= {sr[FRAME_BITS-2:0], dat_q};
        cnt  <= cnt + CW'(1);
        tcnt <= TW'(1);
      end else if (state == SHIFT) begin
        tcnt <= tcnt + TW'(1);
      end

      if (accept) begin
        digits <= sr[31:16];
        flags  <= sr[15:8];
      end

      if (!den_q)
        wait_low <= 1'b0;
      else if (state != IDLE && state_n == IDLE)
        wait_low <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_display_rx.sv
// Self-checking bench for serial_display_rx: scoreboard of expected strobes,
// popped by a negedge monitor; scenario tasks run in sequence.
module tb_serial_display_rx;

  localparam int TIMEOUT = 2047;

  typedef struct {
    bit          ok;
    logic [15:0] dig;
    logic [7:0]  flg;
  } exp_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        ser_clk = 0;
  logic        data = 0;
  logic        data_en = 0;
  logic [15:0] digits;
  logic [7:0]  flags;
  logic        frame_valid;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int strobe_cyc = 0;
  exp_t sb[$];

  serial_display_rx dut (
    .clk         (clk),
    .rst         (rst),
    .ser_clk     (ser_clk),
    .data        (data),
    .data_en     (data_en),
    .digits      (digits),
    .flags       (flags),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (frame_valid === 1'b1 && frame_err === 1'b1) begin
        failures++;
        $display("FAIL both_strobes: valid=1 err=1 required not both");
      end
      if (frame_valid === 1'b1 || frame_err === 1'b1) begin
        exp_t e;
        strobe_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe: valid=%0b err=%0b required none",
                   frame_valid, frame_err);
        end else begin
          e = sb.pop_front();
          if (frame_valid !== e.ok) begin
            failures++;
            $display("FAIL strobe_kind: valid=%0b required %0b",
                     frame_valid, e.ok);
          end else if (e.ok) begin
            checks++;
            if (digits !== e.dig || flags !== e.flg) begin
              failures++;
              $display("FAIL frame_data: got %h/%h required %h/%h",
                       digits, flags, e.dig, e.flg);
            end
          end
        end
      end
    end
  end

  function automatic logic [39:0] mk(input logic [7:0] h,
                                     input logic [15:0] d,
                                     input logic [7:0] f,
                                     input bit good);
    logic [7:0] cs;
    cs = h ^ d[15:8] ^ d[7:0] ^ f;
    return {h, d, f, good ? cs : 8'h00};
  endfunction

  task automatic send_bits(input logic [39:0] f, input int n,
                           input int half, input bit drop);
    @(posedge clk); #1;
    data_en = 1;
    for (int i = 0; i < n; i++) begin
      data = f[39-i];
      repeat (half) @(posedge clk);
      #1 ser_clk = 1;
      last_rise_cyc = cyc;
      repeat (half) @(posedge clk);
      #1 ser_clk = 0;
    end
    if (drop) begin
      repeat (half) @(posedge clk);
      #1 data_en = 0;
      repeat (4) @(posedge clk);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: pending=%0d required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({digits, flags, frame_valid, frame_err, busy} !== 27'd0) begin
      failures++;
      $display("FAIL reset_state: got %h/%h v%0b e%0b b%0b required 0",
               digits, flags, frame_valid, frame_err, busy);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_valid_frame();
    sb.push_back('{1'b1, 16'h1234, 8'h00});
    send_bits(mk(8'hA5, 16'h1234, 8'h00, 1), 40, 300, 1);
    drain("valid");
    checks++;
    if (strobe_cyc !== last_rise_cyc + 4) begin
      failures++;
      $display("FAIL latency: got %0d required %0d",
               strobe_cyc - last_rise_cyc, 4);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_valid: got %0b required 0", busy);
    end
  endtask

  task automatic test_bad_header();
    sb.push_back('{1'b0, 16'h0, 8'h0});
    send_bits(mk(8'h5A, 16'h1234, 8'h00, 1), 40, 10, 1);
    drain("bad_header");
    checks++;
    if (digits !== 16'h1234) begin
      failures++;
      $display("FAIL header_hold: got %h required 1234", digits);
    end
  endtask

  task automatic test_short_frame();
    sb.push_back('{1'b0, 16'h0, 8'h0});
    send_bits(mk(8'hA5, 16'h7777, 8'h00, 1), 20, 10, 1);
    drain("short");
    sb.push_back('{1'b1, 16'h0042, 8'h00});
    send_bits(mk(8'hA5, 16'h0042, 8'h00, 1), 40, 10, 1);
    drain("after_short");
  endtask

  task automatic test_timeout();
    sb.push_back('{1'b0, 16'h0, 8'h0});
    send_bits(mk(8'hA5, 16'h1111, 8'h00, 1), 30, 10, 0);
    drain("timeout");
    checks++;
    if (strobe_cyc !== last_rise_cyc + 2 + TIMEOUT) begin
      failures++;
      $display("FAIL timeout_cycles: got %0d required %0d",
               strobe_cyc - last_rise_cyc - 2, TIMEOUT);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle: busy=%0b required 0", busy);
    end
    #1 data_en = 0;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_checksum();
`ifdef SERIAL_DISPLAY_RX_CHECKSUM_EN
    sb.push_back('{1'b0, 16'h0, 8'h0});
`else
    sb.push_back('{1'b1, 16'h9876, 8'h01});
`endif
    send_bits(mk(8'hA5, 16'h9876, 8'h01, 0), 40, 10, 1);
    drain("checksum");
`ifdef SERIAL_DISPLAY_RX_CHECKSUM_EN
    checks++;
    if (digits !== 16'h0042) begin
      failures++;
      $display("FAIL checksum_hold: got %h required 0042", digits);
    end
`endif
  endtask

  task automatic test_extra_bits();
    sb.push_back('{1'b1, 16'h2468, 8'h02});
    send_bits(mk(8'hA5, 16'h2468, 8'h02, 1), 40, 10, 0);
    send_bits(40'hFF_FFFF_FFFF, 1, 10, 1);
    drain("extra");
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL extra_busy: got %0b required 0", busy);
    end
  endtask

  task automatic test_mid_reset();
    send_bits(mk(8'hA5, 16'h3333, 8'h00, 1), 25, 10, 0);
    #1;
    rst = 1;
    data_en = 0;
    ser_clk = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({digits, flags, frame_valid, frame_err, busy} !== 27'd0) begin
      failures++;
      $display("FAIL mid_reset: got %h/%h v%0b e%0b b%0b required 0",
               digits, flags, frame_valid, frame_err, busy);
    end
    @(posedge clk); #1 rst = 0;
    repeat (6) @(posedge clk);
    sb.push_back('{1'b1, 16'h0555, 8'h01});
    send_bits(mk(8'hA5, 16'h0555, 8'h01, 1), 40, 10, 1);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_header();
    test_short_frame();
    test_timeout();
    test_checksum();
    test_extra_bits();
    test_mid_reset();
    repeat (10) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
